// File: rtl/renkon_ctrl_linebuf_strided.sv
// renkon_ctrl_linebuf_strided: line-buffer controller for the renkon convolution engine.
// Steers pixels into a rotating set of fil_size line memories and produces the
// write strobes, shared address, row-rotation select and window-valid flags.
// Optional feature macro: RENKON_LINEBUF_STRIDE_EN (honour the stride input;
// when undefined, windows are reported at every position, i.e. stride 1).
module renkon_ctrl_linebuf_strided #(
    parameter int unsigned MAXFSIZE = 5,
    parameter int unsigned BUFDEPTH = 256,
    parameter int unsigned SIZEW    = 9,
    parameter int unsigned LWIDTH   = $clog2(BUFDEPTH),
    parameter int unsigned FWIDTH   = $clog2(MAXFSIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [SIZEW-1:0]     img_w,
    input  logic [SIZEW-1:0]     img_h,
    input  logic [FWIDTH-1:0]    fil_size,
    input  logic [1:0]           stride,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [MAXFSIZE-1:0]  buf_we,
    output logic [LWIDTH-1:0]    buf_addr,
    output logic [((MAXFSIZE > 1) ? $clog2(MAXFSIZE) : 1)-1:0] buf_sel,
    output logic                 col_valid,
    output logic                 out_valid,
    output logic                 ack
);

    localparam int unsigned SELW = (MAXFSIZE > 1) ? $clog2(MAXFSIZE) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [SIZEW-1:0]  r_w_m1;
    logic [SIZEW-1:0]  r_h_m1;
    logic [SIZEW-1:0]  r_fil_m1;
    logic [SIZEW-1:0]  r_col;
    logic [SIZEW-1:0]  r_row;
    logic [SELW-1:0]   r_wline;
    logic              r_flush;

    logic              r_in_ready;
    logic [MAXFSIZE-1:0] r_buf_we;
    logic [LWIDTH-1:0] r_buf_addr;
    logic [SELW-1:0]   r_buf_sel;
    logic              r_s1_colv;
    logic              r_s1_outv;
    logic              r_col_valid;
    logic              r_out_valid;
    logic              r_ack;

    logic              w_start;
    logic              w_hs;
    logic              w_col_wrap;
    logic              w_last;
    logic [SELW-1:0]   w_wline_inc;
    logic              w_row_ok;
    logic              w_col_ok;
    logic              w_phase_ok;
    logic              w_in_ready_nxt;
    logic              w_ack_nxt;

    assign w_start     = (r_state == S_IDLE) && req;
    assign w_hs        = in_valid && r_in_ready;
    assign w_col_wrap  = (r_col == r_w_m1);
    assign w_last      = w_col_wrap && (r_row == r_h_m1);
    assign w_wline_inc = (SIZEW'(r_wline) == r_fil_m1) ? SELW'(0) : r_wline + SELW'(1);
    assign w_row_ok    = (r_row >= r_fil_m1);
    assign w_col_ok    = (r_col >= r_fil_m1);

`ifdef RENKON_LINEBUF_STRIDE_EN
    logic [1:0] r_stride_m1;
    logic [1:0] r_cph;
    logic [1:0] r_rph;
    logic [1:0] w_cph_cur;
    logic [1:0] w_rph_cur;
    logic [1:0] w_cph_nxt;
    logic [1:0] w_rph_nxt;

    // Phases restart at the first full-window row/column, so no modulo is needed.
    assign w_cph_cur  = (r_col == r_fil_m1) ? 2'd0 : r_cph;
    assign w_rph_cur  = (r_row == r_fil_m1) ? 2'd0 : r_rph;
    assign w_cph_nxt  = (w_cph_cur == r_stride_m1) ? 2'd0 : w_cph_cur + 2'd1;
    assign w_rph_nxt  = (w_rph_cur == r_stride_m1) ? 2'd0 : w_rph_cur + 2'd1;
    assign w_phase_ok = (w_cph_cur == 2'd0) && (w_rph_cur == 2'd0);

    // Stride phase counters: column phase restarts each row, row phase steps on wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stride_m1 <= 2'd0;
            r_cph       <= 2'd0;
            r_rph       <= 2'd0;
        end else if (w_start) begin
            r_stride_m1 <= (stride == 2'd0) ? 2'd0 : stride - 2'd1;
            r_cph       <= 2'd0;
            r_rph       <= 2'd0;
        end else if (w_hs) begin
            r_cph <= w_col_wrap ? 2'd0 : w_cph_nxt;
            if (w_col_wrap) begin
                r_rph <= w_rph_nxt;
            end
        end
    end
`else
    logic w_unused_stride;
    assign w_unused_stride = ^stride;
    assign w_phase_ok      = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (req) w_state_nxt = S_FILL;
            S_FILL: begin
                if (w_hs && w_last) begin
                    w_state_nxt = S_FLUSH;
                end else if (w_row_ok) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN:   if (w_hs && w_last) w_state_nxt = S_FLUSH;
            S_FLUSH: if (r_flush) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state; registered below.
    always_comb begin
        w_in_ready_nxt = 1'b0;
        w_ack_nxt      = 1'b0;
        w_in_ready_nxt = (w_state_nxt == S_FILL) || (w_state_nxt == S_RUN);
        w_ack_nxt      = (w_state_nxt == S_DONE);
    end

    // Handshake/done outputs and the two-cycle flush timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready <= 1'b0;
            r_ack      <= 1'b0;
            r_flush    <= 1'b0;
        end else begin
            r_in_ready <= w_in_ready_nxt;
            r_ack      <= w_ack_nxt;
            r_flush    <= (r_state == S_FLUSH);
        end
    end

    // Configuration capture on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_m1   <= '0;
            r_h_m1   <= '0;
            r_fil_m1 <= '0;
        end else if (w_start) begin
            r_w_m1   <= img_w - SIZEW'(1);
            r_h_m1   <= img_h - SIZEW'(1);
            r_fil_m1 <= (fil_size == FWIDTH'(0)) ? SIZEW'(0) : SIZEW'(fil_size) - SIZEW'(1);
        end
    end

    // Column/row/write-line counters; stall on bubbles.
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_col   <= '0;
            r_row   <= '0;
            r_wline <= '0;
        end else if (w_hs) begin
            if (w_col_wrap) begin
                r_col   <= '0;
                r_row   <= r_row + SIZEW'(1);
                r_wline <= w_wline_inc;
            end else begin
                r_col   <= r_col + SIZEW'(1);
            end
        end
    end

    // Memory strobes: write one-hot pulses per handshake, address and select hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_we   <= '0;
            r_buf_addr <= '0;
            r_buf_sel  <= '0;
        end else begin
            r_buf_we <= '0;
            if (w_hs) begin
                r_buf_we   <= MAXFSIZE'(1) << r_wline;
                r_buf_addr <= LWIDTH'(r_col);
                r_buf_sel  <= w_wline_inc;
            end
        end
    end

    // Window flags, delayed one extra cycle to line up with memory read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_colv   <= 1'b0;
            r_s1_outv   <= 1'b0;
            r_col_valid <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_s1_colv   <= w_hs && w_row_ok;
            r_s1_outv   <= w_hs && w_row_ok && w_col_ok && w_phase_ok;
            r_col_valid <= r_s1_colv;
            r_out_valid <= r_s1_outv;
        end
    end

    assign in_ready  = r_in_ready;
    assign buf_we    = r_buf_we;
    assign buf_addr  = r_buf_addr;
    assign buf_sel   = r_buf_sel;
    assign col_valid = r_col_valid;
    assign out_valid = r_out_valid;
    assign ack       = r_ack;

endmodule

// File: doc/renkon_ctrl_linebuf_strided.md
# renkon_ctrl_linebuf_strided

Parametrised line-buffer controller for the renkon convolution engine. Sits between the input-feature-map reader and the line-buffer memory bank plus window shift registers. It steers incoming pixels into a rotating set of line memories and emits the write/read strobes, the row-rotation select and window-valid flags for runtime-selectable filter size, image dimensions and stride. It generalises the fixed-geometry line-buffer controller.

## Interface

Parameters:
- `MAXFSIZE`, 5: maximum filter size; line memories = `MAXFSIZE`.
- `BUFDEPTH`, 256: entries per line memory (max image width).
- `SIZEW`, 9: width of the image-dimension inputs.
- `LWIDTH`, `$clog2(BUFDEPTH)`: derived line-address width.
- `FWIDTH`, `$clog2(MAXFSIZE+1)`: derived filter-size width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `req` in 1: start pulse; samples configuration.
- `img_w` in `SIZEW`: image width, 1..`BUFDEPTH`.
- `img_h` in `SIZEW`: image height, ≥1.
- `fil_size` in `FWIDTH`: filter size, 1..`MAXFSIZE`; 0 treated as 1.
- `stride` in 2: 1..3; 0 treated as 1.
- `in_valid` in 1: upstream pixel valid.
- `in_ready` out 1: controller accepts a pixel.
- `buf_we` out `MAXFSIZE`: one-hot line-memory write enable.
- `buf_addr` out `LWIDTH`: shared line-memory address (write and read).
- `buf_sel` out `$clog2(MAXFSIZE)`: index of the oldest stored line; window-row rotation.
- `col_valid` out 1: one full window column present on memory outputs plus input register.
- `out_valid` out 1: complete window at a strided position.
- `ack` out 1: one-cycle done pulse.

## Operation

- States: `S_IDLE` → (`req`) `S_FILL` → (row counter reaches `fil_size-1`) `S_RUN` → (last pixel accepted) `S_FLUSH` → (pipeline empty) `S_DONE` → `S_IDLE`.
- `req` in any state other than `S_IDLE` is ignored. Configuration is latched on `req`.
- `in_ready` = 1 in `S_FILL` and `S_RUN` only. Handshake = `in_valid & in_ready`.
- Per handshake:
  - `col` increments and wraps at `img_w-1`.
  - On wrap, `row` increments and `wline` advances, wrapping at `fil_size-1` (not `MAXFSIZE`).
- `buf_we` = one-hot(`wline`). `buf_addr` = `col`. Memories are read-before-write, so old lines appear at the same address.
- `buf_sel` = (`wline`+1) mod `fil_size`, clamped to 0 when `fil_size`=1. It updates with `buf_we`.
- `col_valid` is asserted for each handshake with `row ≥ fil_size-1`.
- `out_valid` additionally requires `col ≥ fil_size-1`, plus the stride phase:
  - Phase counters reset to 0 at `row`/`col` = `fil_size-1` and at each row start.
  - Assert only when both phase counters = 0; counters wrap at `stride-1`. No modulo arithmetic.
- `fil_size > img_h`: no `col_valid` or `out_valid`. `ack` still follows the last pixel.
- `rst` at any point: state `S_IDLE`, all counters 0, all outputs 0 on the next edge.

## Timing

- Reset value of every output: 0.
- Handshake at cycle t → `buf_we`/`buf_addr`/`buf_sel` valid at t+1 (registered). Memory read data at t+2.
- `col_valid`/`out_valid` at t+2, aligned with memory read data.
- `buf_we` is 0 in cycles without a handshake. `buf_addr` holds its value.
- `ack` at t_last+3, exactly one cycle. `S_IDLE` reached at t_last+4; a new `req` is accepted from that cycle.
- Bubbles in `in_valid` stall all counters. Output pulses stay one per handshake.

## Configuration

- `RENKON_LINEBUF_STRIDE_EN` defined:
  - `stride` input honoured as above.
- `RENKON_LINEBUF_STRIDE_EN` undefined:
  - `stride` port present but ignored; phase counters removed.
  - `out_valid` = `col_valid & (col ≥ fil_size-1)`, i.e. stride 1.

## Test plan

- w=8, h=8, fil=3, stride=1, continuous `in_valid` → 64 handshakes, 48 `col_valid`, 36 `out_valid`, single `ack` 3 cycles after last handshake.
- Same image, stride=2 → 9 `out_valid` at (row,col) ∈ {2,4,6}²; with macro undefined → 36.
- w=12, h=6, fil=5 → `buf_we` sequence 1,2,4,8,16,1 per row; `buf_sel`=1 during row 5; `out_valid` count 16.
- `in_valid` toggling every other cycle, w=8, h=8, fil=3 → counts identical to the first scenario; `buf_addr` steps only on handshakes; `buf_we`=0 in gap cycles.
- `rst` asserted after pixel 20 → next cycle all outputs 0 and `in_ready`=0; a following `req` restarts with `buf_we`=1, `buf_addr`=0.
- `req` pulsed mid-run → ignored, counts unchanged. Then fil=5, h=3 → zero `col_valid`, `ack` 3 cycles after pixel h·w.
